// File: rtl/uart_tx_sched_if.sv
// Requester-side and transmitter-side signals of the UART TX scheduler, bundled as one interface.
// The slave modport is the scheduler's view; master is the clients/transmitter view.
interface uart_tx_sched_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                          en;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [IdW-1:0]                grant_id;
  logic [DATA_WIDTH-1:0]         tx_p_data;
  logic                          tx_data_valid;
  logic                          tx_busy;
  logic                          sched_busy;
  logic                          err_timeout;

  modport slave (
    input  en,
    input  req,
    input  req_data,
    input  tx_busy,
    output gnt,
    output grant_id,
    output tx_p_data,
    output tx_data_valid,
    output sched_busy,
    output err_timeout
  );

  modport master (
    output en,
    output req,
    output req_data,
    output tx_busy,
    input  gnt,
    input  grant_id,
    input  tx_p_data,
    input  tx_data_valid,
    input  sched_busy,
    input  err_timeout
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte requesters.
// Grants one request per frame, strobes the byte to the transmitter and tracks tx_busy.
module uart_tx_sched #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_sched_if.slave bus
);
  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TmW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic [IdW-1:0]        r_grant_id;
  logic [IdW-1:0]        w_grant_id_d;
  logic [IdW-1:0]        r_last;
  logic [IdW-1:0]        w_last_d;
  logic [DATA_WIDTH-1:0] r_tx_p_data;
  logic [DATA_WIDTH-1:0] w_tx_p_data_d;
  logic [TmW-1:0]        r_timer;
  logic [TmW-1:0]        w_timer_d;
  logic                  r_err;
  logic                  w_err_d;

  logic [IdW-1:0]        w_pick;
  logic                  w_pick_vld;
  logic [DATA_WIDTH-1:0] w_pick_data;
  logic [NUM_REQ-1:0]    w_gnt;

  function automatic logic [IdW-1:0] rr_idx(input logic [IdW-1:0] base, input int unsigned off);
    int unsigned s;
    s = (int'(base) + off) % NUM_REQ;
    return IdW'(s);
  endfunction

  // Search starts just after the last winner so every requester waits at most NUM_REQ-1 frames.
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      if (!w_pick_vld && bus.req[rr_idx(r_last, off)]) begin
        w_pick     = rr_idx(r_last, off);
        w_pick_vld = 1'b1;
      end
    end
  end

  assign w_pick_data = bus.req_data[int'(w_pick)*int'(DATA_WIDTH) +: DATA_WIDTH];

  always_comb begin
    w_state_d     = r_state;
    w_grant_id_d  = r_grant_id;
    w_last_d      = r_last;
    w_tx_p_data_d = r_tx_p_data;
    w_timer_d     = r_timer;
    w_err_d       = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.en && w_pick_vld) begin
          w_grant_id_d  = w_pick;
          w_tx_p_data_d = w_pick_data;
          w_state_d     = StIssue;
        end
      end
      StIssue: begin
        w_last_d  = r_grant_id;
        w_timer_d = '0;
        w_state_d = StWaitBusy;
      end
      StWaitBusy: begin
        // Busy already high on entry (foreign source) counts as the frame having started.
        if (bus.tx_busy) begin
          w_state_d = StWaitDone;
        end else if (r_timer == TmW'(BUSY_TIMEOUT - 1)) begin
          w_err_d   = 1'b1;
          w_state_d = StIdle;
        end else begin
          w_timer_d = r_timer + 1'b1;
        end
      end
      StWaitDone: begin
        if (!bus.tx_busy) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_grant_id  <= '0;
      r_last      <= IdW'(NUM_REQ - 1);
      r_tx_p_data <= '0;
      r_timer     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_grant_id  <= w_grant_id_d;
      r_last      <= w_last_d;
      r_tx_p_data <= w_tx_p_data_d;
      r_timer     <= w_timer_d;
      r_err       <= w_err_d;
    end
  end

  always_comb begin
    w_gnt = '0;
    if (r_state == StIssue) begin
      w_gnt[r_grant_id] = 1'b1;
    end
  end

  assign bus.gnt           = w_gnt;
  assign bus.grant_id      = r_grant_id;
  assign bus.tx_p_data     = r_tx_p_data;
  assign bus.tx_data_valid = (r_state == StIssue);
  assign bus.sched_busy    = (r_state != StIdle);
  assign bus.err_timeout   = r_err;
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmitter between NUM_REQ byte requesters. It arbitrates pending requests and latches the winner's byte. It then drives the transmitter's parallel data and one-cycle data-valid strobe, and tracks the transmitter busy flag until the frame completes. It sits between the requesting clients and the UART TX top level (serializer, parity, mux, TX FSM).

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width on each requester and on the TX data port
BUSY_TIMEOUT, 16, cycles to wait for tx_busy to rise after the strobe before aborting (>=2)

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  asynchronous, active-low reset
en  in  1  scheduler enable; 0 blocks new arbitration only
req  in  NUM_REQ  per-requester transmit request, level
req_data  in  NUM_REQ*DATA_WIDTH  requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
gnt  out  NUM_REQ  one-cycle pulse: requester's byte accepted
grant_id  out  clog2(NUM_REQ)  index of current/last granted requester
tx_p_data  out  DATA_WIDTH  byte to UART TX
tx_data_valid  out  1  one-cycle strobe to UART TX
tx_busy  in  1  UART TX busy flag
sched_busy  out  1  high whenever state != IDLE
err_timeout  out  1  one-cycle pulse: tx_busy never rose

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-low.
- All outputs are registered or decoded from registered state. No combinational path from input to output.
- Reset values: state IDLE, tx_p_data 0, tx_data_valid 0, gnt 0, grant_id 0, sched_busy 0, err_timeout 0, timer 0, rr pointer last = NUM_REQ-1 (so requester 0 wins first).
- Reset mid-frame returns to IDLE immediately. The partially sent UART frame is not the scheduler's concern.
- Requester protocol: hold req high and req_data stable until gnt. Request withdrawal before gnt is illegal and is not checked.
- State IDLE:
  - If en=1 and |req, select the first set req bit searching last+1, last+2, ... modulo NUM_REQ.
  - Latch that requester's req_data into tx_p_data and its index into grant_id. Go to ISSUE.
  - Otherwise stay in IDLE. en=0 with pending req: stay in IDLE, no gnt.
- State ISSUE, exactly 1 cycle:
  - tx_data_valid=1 and gnt[grant_id]=1.
  - last <= grant_id. timer <= 0. Go to WAIT_BUSY.
- State WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise timer increments.
  - timer==BUSY_TIMEOUT-1 with tx_busy=0: err_timeout pulse 1 cycle, go to IDLE (rr pointer already advanced).
- State WAIT_DONE: stay while tx_busy=1. On tx_busy=0 go to IDLE.
- Latency: req rising in IDLE at edge t gives tx_data_valid and gnt high during cycle t+1.
- Next strobe: no earlier than 2 cycles after tx_busy falls (IDLE, then ISSUE). The scheduler never strobes while tx_busy=1, so it never uses the transmitter's back-to-back STOP->START path.
- tx_p_data is held stable from ISSUE until the next arbitration in IDLE.
- tx_busy high on entry to WAIT_BUSY (e.g. busy already high from a foreign source) is accepted as started.
- gnt is one-hot or zero. tx_data_valid is never high in two consecutive cycles.
- en changes mid-frame have no effect until IDLE.
- Simultaneous requests: exactly one granted per frame. Any requester waits at most NUM_REQ-1 frames.

Test Plan:
- Single request: req=0001, req_data[7:0]=0xA5, TX model raises busy 1 cycle after strobe for 11 cycles -> gnt=0001 and tx_data_valid 1 cycle after req; tx_p_data=0xA5; sched_busy high until busy falls; IDLE next cycle.
- Round-robin: req=1111 held, data 0x10/0x21/0x32/0x43, each requester drops req after its gnt -> grant order 0,1,2,3; tx_p_data sequence 0x10,0x21,0x32,0x43; exactly 4 strobes, none while tx_busy=1.
- Fairness: req[0] and req[2] permanently high, 6 frames -> grant_id alternates 0,2,0,2,0,2.
- Timeout: tx_busy tied 0, req=0010 -> strobe, then err_timeout pulses exactly 16 cycles after ISSUE; back to IDLE; next req=0001 granted normally.
- Reset mid-frame: assert RST low during WAIT_DONE -> all outputs 0 asynchronously; after release, req=1000 -> requester 0 priority restored, so with req=1001 grant_id=0.
- Enable gating: en=0, req=0100 for 20 cycles -> no gnt or strobe; en=1 -> gnt[2] after 1 cycle.
